lc4_rob_ctrl: RTL and testbench

Sequencing controller for the out-of-order LC4 back end. It allocates 2-bit ROB indices to dispatching instructions and tracks their completion. It retires instructions in order and drives the `stall`/`flush` inputs of the `lc4_pipeline_latch` stages around it. A mispredicted branch reaching the head squashes all younger state and redirects fetch.

---
 rtl/lc4_rob_pkg.sv | 18 +
 rtl/lc4_rob_entry.sv | 40 ++++
 rtl/lc4_rob_ctrl.sv | 101 ++++++++++
 tb/tb_lc4_rob_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lc4_rob_pkg.sv
// Shared sizing constants and the ROB entry record for the LC4 out-of-order back end.
package lc4_rob_pkg;

  localparam int IDX_W     = 2;
  localparam int ROB_DEPTH = 1 << IDX_W;
  localparam int PREG_W    = 4;
  localparam int PC_W      = 16;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispred;
    logic              has_rd;
    logic [PREG_W-1:0] prd;
    logic [PC_W-1:0]   redirect;
  } rob_entry_t;

endpackage

// File: rtl/lc4_rob_entry.sv
// One ROB slot: flag and payload register with clear, dispatch-write and completion-write ports.
module lc4_rob_entry
  import lc4_rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_valid,
  input  logic              disp_we,
  input  logic [PREG_W-1:0] disp_prd,
  input  logic              disp_has_rd,
  input  logic              cmpl_we,
  input  logic              cmpl_mispred,
  input  logic [PC_W-1:0]   cmpl_redirect,
  output rob_entry_t        entry
);

  // Priority: reset, then clear, then dispatch, then completion. A completion
  // only lands on a live entry; stale tags from squashed work fall through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the payload is reset as well (not just valid) so the head's prd/has_rd read 0 out of reset.
      entry <= '0;
    end else if (clr_valid) begin
      // NOTE: non-blocking assignment for every sequential update, so all slots sample the same pre-edge state.
      entry.valid <= 1'b0;
    end else if (disp_we) begin
      entry.valid    <= 1'b1;
      entry.done     <= 1'b0;
      entry.mispred  <= 1'b0;
      entry.has_rd   <= disp_has_rd;
      entry.prd      <= disp_prd;
      entry.redirect <= '0;
    end else if (cmpl_we && entry.valid) begin
      entry.done     <= 1'b1;
      entry.mispred  <= cmpl_mispred;
      entry.redirect <= cmpl_redirect;
    end
  end

endmodule

// File: rtl/lc4_rob_ctrl.sv
// ROB sequencing controller: allocates indices, tracks completion, retires in order, squashes on mispredict.
module lc4_rob_ctrl #(
  parameter int ROB_DEPTH = lc4_rob_pkg::ROB_DEPTH,
  parameter int IDX_W     = lc4_rob_pkg::IDX_W,
  parameter int PREG_W    = lc4_rob_pkg::PREG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gwe,
  input  logic              disp_valid,
  input  logic [PREG_W-1:0] disp_prd,
  input  logic              disp_has_rd,
  output logic              disp_ready,
  output logic [IDX_W-1:0]  disp_rob_index,
  output logic              stall_front,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_rob_index,
  input  logic              cmpl_mispredict,
  input  logic [15:0]       cmpl_pc_redirect,
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_rob_index,
  output logic [PREG_W-1:0] commit_prd,
  output logic              commit_has_rd,
  output logic              flush,
  output logic [15:0]       redirect_pc
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(ROB_DEPTH);

  lc4_rob_pkg::rob_entry_t ents [ROB_DEPTH];
  lc4_rob_pkg::rob_entry_t head_ent;

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;
  logic             flush_r;
  logic [15:0]      redirect_r;

  logic disp_fire, commit_fire, recover, cmpl_fire;

  assign head_ent = ents[head];

  // A full ROB blocks dispatch even when the head retires this cycle.
  assign disp_ready   = rst & ~flush_r & (count < FULL_COUNT);
  assign commit_valid = head_ent.valid & head_ent.done & ~flush_r;

  assign disp_fire   = disp_valid & disp_ready & gwe;
  assign commit_fire = commit_valid & gwe;
  assign recover     = commit_fire & head_ent.mispred;
  assign cmpl_fire   = cmpl_valid & gwe & ~flush_r;

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_entry
    lc4_rob_entry u_entry (
      .clk          (clk),
      .rst          (rst),
      .clr_valid    (recover | (commit_fire & (head == IDX_W'(i)))),
      .disp_we      (disp_fire & ~recover & (tail == IDX_W'(i))),
      .disp_prd     (disp_prd),
      .disp_has_rd  (disp_has_rd),
      .cmpl_we      (cmpl_fire & (cmpl_rob_index == IDX_W'(i))),
      .cmpl_mispred (cmpl_mispredict),
      .cmpl_redirect(cmpl_pc_redirect),
      .entry        (ents[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      flush_r    <= 1'b0;
      redirect_r <= '0;
    end else if (gwe) begin
      flush_r <= recover;
      if (recover) begin
        // Squash: the dispatch that may fire alongside the mispredicted commit is dropped.
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        redirect_r <= head_ent.redirect;
      end else begin
        if (disp_fire)   tail <= tail + 1'b1;
        if (commit_fire) head <= head + 1'b1;
        case ({disp_fire, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign stall_front      = ~disp_ready;
  assign disp_rob_index   = tail;
  assign commit_rob_index = head;
  assign commit_prd       = head_ent.prd;
  assign commit_has_rd    = head_ent.has_rd;
  assign flush            = flush_r;
  assign redirect_pc      = redirect_r;

endmodule

// File: tb/tb_lc4_rob_ctrl.sv
// Scoreboard bench for lc4_rob_ctrl: a queue-based ROB model predicts outputs, a monitor compares them.
module tb_lc4_rob_ctrl;

  logic        clk = 1'b0;
  logic        rst, gwe, disp_valid, disp_has_rd, cmpl_valid, cmpl_mispredict;
  logic [3:0]  disp_prd;
  logic [1:0]  cmpl_rob_index;
  logic [15:0] cmpl_pc_redirect;
  logic        disp_ready, stall_front, commit_valid, commit_has_rd, flush;
  logic [1:0]  disp_rob_index, commit_rob_index;
  logic [3:0]  commit_prd;
  logic [15:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lc4_rob_ctrl dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .disp_valid(disp_valid), .disp_prd(disp_prd), .disp_has_rd(disp_has_rd),
    .disp_ready(disp_ready), .disp_rob_index(disp_rob_index), .stall_front(stall_front),
    .cmpl_valid(cmpl_valid), .cmpl_rob_index(cmpl_rob_index),
    .cmpl_mispredict(cmpl_mispredict), .cmpl_pc_redirect(cmpl_pc_redirect),
    .commit_valid(commit_valid), .commit_rob_index(commit_rob_index),
    .commit_prd(commit_prd), .commit_has_rd(commit_has_rd),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  // Reference model: the ROB is an ordered queue of in-flight instructions.
  typedef struct {
    int          idx;
    logic [3:0]  prd;
    logic        has_rd;
    bit          done;
    bit          mis;
    logic [15:0] redir;
  } rec_t;

  typedef struct {
    bit          dr;
    logic [1:0]  didx;
    bit          cv;
    bit          fl;
    logic [15:0] rd;
  } cyc_t;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] prd;
    logic       hr;
  } cm_t;

  rec_t rob[$];
  cyc_t cyc_q[$];
  cm_t  cm_q[$];
  int          m_tail = 0;
  bit          m_flush = 1'b0;
  logic [15:0] m_redirect = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, record the expected outputs, advance the model past the edge.
  task automatic cycle(input bit r, input bit g, input bit dv, input logic [3:0] dp, input bit dh,
                       input bit cv, input logic [1:0] ci, input bit cm, input logic [15:0] cr);
    bit ready, com, nf;
    @(negedge clk);
    rst = r; gwe = g; disp_valid = dv; disp_prd = dp; disp_has_rd = dh;
    cmpl_valid = cv; cmpl_rob_index = ci; cmpl_mispredict = cm; cmpl_pc_redirect = cr;

    ready = r && !m_flush && (rob.size() < 4);
    com   = (rob.size() > 0) && rob[0].done && !m_flush;
    cyc_q.push_back('{ready, 2'(m_tail), com, m_flush, m_redirect});
    if (com) cm_q.push_back('{2'(rob[0].idx), rob[0].prd, rob[0].has_rd});

    if (!r) begin
      rob.delete();
      m_tail = 0; m_flush = 1'b0; m_redirect = 16'h0;
    end else if (g) begin
      nf = 1'b0;
      if (com && rob[0].mis) begin
        m_redirect = rob[0].redir;
        rob.delete();
        m_tail = 0;
        nf = 1'b1;
      end else begin
        if (cv && !m_flush)
          foreach (rob[k])
            if (rob[k].idx == int'(ci)) begin
              rob[k].done = 1'b1; rob[k].mis = cm; rob[k].redir = cr;
            end
        if (com) void'(rob.pop_front());
        if (dv && ready) begin
          rob.push_back('{m_tail, dp, dh, 1'b0, 1'b0, 16'h0});
          m_tail = (m_tail + 1) % 4;
        end
      end
      m_flush = nf;
    end
  endtask

  task automatic idle(input bit dv);
    cycle(1'b1, 1'b1, dv, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0);
  endtask

  task automatic complete(input logic [1:0] ci, input bit cm, input logic [15:0] cr, input bit dv);
    cycle(1'b1, 1'b1, dv, 4'hE, 1'b0, 1'b1, ci, cm, cr);
  endtask

  // Monitor: compares what the DUT presents against the scoreboard, mid-cycle.
  always begin
    cyc_t e;
    cm_t  c;
    @(negedge clk);
    #2;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("disp_ready", 32'(disp_ready), 32'(e.dr));
      check("stall_front", 32'(stall_front), 32'(!e.dr));
      check("disp_rob_index", 32'(disp_rob_index), 32'(e.didx));
      check("commit_valid", 32'(commit_valid), 32'(e.cv));
      check("flush", 32'(flush), 32'(e.fl));
      check("redirect_pc", 32'(redirect_pc), 32'(e.rd));
      if (commit_valid === 1'b1) begin
        if (cm_q.size() == 0) begin
          check("commit_expected", 32'(cm_q.size()), 32'd1);
        end else begin
          c = cm_q.pop_front();
          check("commit_rob_index", 32'(commit_rob_index), 32'(c.idx));
          check("commit_prd", 32'(commit_prd), 32'(c.prd));
          check("commit_has_rd", 32'(commit_has_rd), 32'(c.hr));
        end
      end
    end
  end

  initial begin
    bit   r, g, dv, cv, cm;
    logic [1:0] ci;
    rst = 1'b0; gwe = 1'b1; disp_valid = 1'b0; disp_prd = '0; disp_has_rd = 1'b0;
    cmpl_valid = 1'b0; cmpl_rob_index = '0; cmpl_mispredict = 1'b0; cmpl_pc_redirect = '0;
    @(posedge clk);

    // Reset held two cycles, then fill the ROB and try a fifth dispatch.
    cycle(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0);
    #3;
    check("rst_commit_prd", 32'(commit_prd), 32'd0);
    check("rst_commit_has_rd", 32'(commit_has_rd), 32'd0);
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 1'b1, 1'b1, 4'(i), i[0], 1'b0, 2'd0, 1'b0, 16'h0);
    idle(1'b1);

    // Out-of-order completion, in-order retirement; full-plus-commit then wrap to index 0.
    complete(2'd2, 1'b0, 16'h0, 1'b1);
    complete(2'd1, 1'b0, 16'h0, 1'b1);
    complete(2'd0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Mispredict at index 1.
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0);
    complete(2'd0, 1'b0, 16'h0, 1'b0);
    complete(2'd1, 1'b1, 16'h0040, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // gwe gating on dispatch and completion.
    cycle(1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) idle(1'b0);

    // Reset asserted in the flush cycle.
    idle(1'b1);
    for (int i = 0; i < 4; i++) complete(2'(i), 1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 10 && !m_flush; i++) idle(1'b0);
    cycle(1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0);
    idle(1'b0);
    idle(1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) != 0);
      g  = ($urandom_range(0, 7) != 0);
      dv = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 3) != 0);
      cm = ($urandom_range(0, 9) == 0);
      if (rob.size() > 0 && $urandom_range(0, 3) != 0)
        ci = 2'(rob[$urandom_range(0, rob.size() - 1)].idx);
      else
        ci = 2'($urandom_range(0, 3));
      cycle(r, g, dv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            cv, ci, cm, 16'($urandom));
    end

    @(negedge clk);
    #4;
    check("commit_queue_drained", 32'(cm_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
